// File: rtl/decode_stage.sv
// Registered MIPS decode stage (ID) with valid/ready handshake, load-use bubble and flush.
// Optional DECODE_PERF_EN adds saturating bubble_cnt / illegal_cnt performance counters.
module decode_stage #(
  parameter int DWIDTH = 32,
  parameter int RAW    = 5
`ifdef DECODE_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        op,
  output logic              ssel,
  output logic [DWIDTH-1:0] imm,
  output logic [RAW-1:0]    rs1_id,
  output logic [RAW-1:0]    rs2_id,
  output logic [RAW-1:0]    rdst_id,
  output logic [2:0]        jump_type,
  output logic [DWIDTH-1:0] jump_addr,
  output logic              we_dmem,
  output logic              we_regfile,
  output logic              is_load,
  output logic              illegal
`ifdef DECODE_PERF_EN
  ,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
`endif
);

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_SLTI = 6'b001010;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_JAL  = 6'b000011;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2a;
  localparam logic [5:0] F_JR  = 6'h08;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_JR    = 4'b1000;
  localparam logic [3:0] ALU_UNDEF = 4'b1111;

  localparam logic [2:0] JT_BEQ = 3'd1;
  localparam logic [2:0] JT_J   = 3'd2;
  localparam logic [2:0] JT_JAL = 3'd3;
  localparam logic [2:0] JT_JR  = 3'd4;

  localparam int BW = 4 + 1 + DWIDTH + 3*RAW + 3 + DWIDTH + 4;
  localparam logic [BW-1:0] IDLE = {ALU_UNDEF, {(BW-4){1'b0}}};

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [3:0]        d_op;
  logic              d_ssel;
  logic [DWIDTH-1:0] d_imm;
  logic [RAW-1:0]    d_rs1;
  logic [RAW-1:0]    d_rs2;
  logic [RAW-1:0]    d_rdst;
  logic [2:0]        d_jt;
  logic [DWIDTH-1:0] d_ja;
  logic              d_wd;
  logic              d_wr;
  logic              d_ld;
  logic              d_ill;
  logic [BW-1:0]     d_bus;
  logic [BW-1:0]     q_bus;
  logic              load_en;
  logic              hazard;
  logic              take;
  logic              unused_shamt;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    d_op   = ALU_UNDEF;
    d_ssel = 1'b0;
    d_imm  = '0;
    d_rs1  = '0;
    d_rs2  = '0;
    d_rdst = '0;
    d_jt   = '0;
    d_ja   = '0;
    d_wd   = 1'b0;
    d_wr   = 1'b0;
    d_ld   = 1'b0;
    d_ill  = 1'b0;
    case (opcode)
      OPC_R: begin
        case (funct)
          F_ADD:   d_op = ALU_ADD;
          F_SUB:   d_op = ALU_SUB;
          F_AND:   d_op = ALU_AND;
          F_OR:    d_op = ALU_OR;
          F_NOR:   d_op = ALU_NOR;
          F_SLT:   d_op = ALU_SLT;
          F_JR:    d_op = ALU_JR;
          default: d_op = ALU_UNDEF;
        endcase
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT: begin
            d_ssel = 1'b1;
            d_rs1  = RAW'(instr[25:21]);
            d_rs2  = RAW'(instr[20:16]);
            d_rdst = RAW'(instr[15:11]);
            d_wr   = 1'b1;
          end
          F_JR: begin
            d_ssel = 1'b1;
            d_rs1  = RAW'(instr[25:21]);
            d_jt   = JT_JR;
          end
          default: d_ill = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_SLTI, OPC_LW: begin
        d_op   = (opcode == OPC_SLTI) ? ALU_SLT : ALU_ADD;
        d_imm  = {{(DWIDTH-16){instr[15]}}, instr[15:0]};
        d_rs1  = RAW'(instr[25:21]);
        d_rdst = RAW'(instr[20:16]);
        d_wr   = 1'b1;
        d_ld   = (opcode == OPC_LW);
      end
      OPC_SW: begin
        d_op  = ALU_ADD;
        d_imm = {{(DWIDTH-16){instr[15]}}, instr[15:0]};
        d_rs1 = RAW'(instr[25:21]);
        d_rs2 = RAW'(instr[20:16]);
        d_wd  = 1'b1;
      end
      OPC_BEQ: begin
        d_op   = ALU_SUB;
        d_ssel = 1'b1;
        d_imm  = {{(DWIDTH-16){instr[15]}}, instr[15:0]};
        d_rs1  = RAW'(instr[25:21]);
        d_rs2  = RAW'(instr[20:16]);
        d_jt   = JT_BEQ;
      end
      OPC_J: begin
        d_jt = JT_J;
        d_ja = {{(DWIDTH-26){1'b0}}, instr[25:0]};
      end
      OPC_JAL: begin
        d_jt   = JT_JAL;
        d_ja   = {{(DWIDTH-26){1'b0}}, instr[25:0]};
        d_rdst = '1;
        d_wr   = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
  end

  assign d_bus = {d_op, d_ssel, d_imm, d_rs1, d_rs2, d_rdst, d_jt, d_ja, d_wd, d_wr, d_ld, d_ill};
  assign {op, ssel, imm, rs1_id, rs2_id, rdst_id, jump_type, jump_addr,
          we_dmem, we_regfile, is_load, illegal} = q_bus;

  // Unused source fields decode to 0 and a hazard needs rdst_id != 0,
  // so comparing against the decoded IDs counts rs2 only where it is used.
  assign load_en  = !out_valid || out_ready;
  assign hazard   = out_valid && is_load && (rdst_id != '0) && in_valid &&
                    ((rdst_id == d_rs1) || (rdst_id == d_rs2));
  assign in_ready = rst_n && load_en && !hazard && !flush;
  assign take     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_valid <= 1'b0;
      q_bus     <= IDLE;
    end else if (load_en) begin
      out_valid <= take;
      q_bus     <= take ? d_bus : IDLE;
    end
  end

`ifdef DECODE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt  <= '0;
      illegal_cnt <= '0;
    end else begin
      if (!flush && load_en && hazard && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (take && d_ill && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver pushes model decodes on acceptance, monitor pops and compares.
module tb_decode_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic        ssel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rdst;
    logic [2:0]  jt;
    logic [31:0] ja;
    logic        wd;
    logic        wr;
    logic        ld;
    logic        ill;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  op;
  logic        ssel;
  logic [31:0] imm;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic [4:0]  rdst_id;
  logic [2:0]  jump_type;
  logic [31:0] jump_addr;
  logic        we_dmem;
  logic        we_regfile;
  logic        is_load;
  logic        illegal;
`ifdef DECODE_PERF_EN
  logic [15:0] bubble_cnt;
  logic [15:0] illegal_cnt;
  int          exp_bub = 0;
  int          exp_ill = 0;
`endif

  int   errors = 0;
  int   checks = 0;
  bit   started = 1'b0;
  logic exp_ready = 1'b0;
  dec_t sb[$];

  decode_stage #(.DWIDTH(32), .RAW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .op(op), .ssel(ssel),
    .imm(imm), .rs1_id(rs1_id), .rs2_id(rs2_id), .rdst_id(rdst_id), .jump_type(jump_type),
    .jump_addr(jump_addr), .we_dmem(we_dmem), .we_regfile(we_regfile), .is_load(is_load),
    .illegal(illegal)
`ifdef DECODE_PERF_EN
    , .bubble_cnt(bubble_cnt), .illegal_cnt(illegal_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic dec_t idle_dec();
    dec_t d;
    d = '0;
    d.op = 4'b1111;
    return d;
  endfunction

  // Reference decode built from the instruction-set table.
  function automatic dec_t model(input logic [31:0] w);
    dec_t d;
    logic [5:0] opc;
    logic [5:0] fn;
    logic [3:0] alu;
    logic [31:0] sx;
    opc = w[31:26];
    fn  = w[5:0];
    sx  = {{16{w[15]}}, w[15:0]};
    d   = idle_dec();
    alu = 4'b1111;
    case (fn)
      6'h20: alu = 4'b0010;
      6'h22: alu = 4'b0110;
      6'h24: alu = 4'b0000;
      6'h25: alu = 4'b0001;
      6'h27: alu = 4'b1100;
      6'h2a: alu = 4'b0111;
      default: alu = 4'b1111;
    endcase
    if (opc == 6'h00 && fn == 6'h08) begin
      d.op = 4'b1000; d.ssel = 1'b1; d.rs1 = w[25:21]; d.jt = 3'd4;
    end else if (opc == 6'h00 && alu != 4'b1111) begin
      d.op = alu; d.ssel = 1'b1; d.rs1 = w[25:21]; d.rs2 = w[20:16]; d.rdst = w[15:11]; d.wr = 1'b1;
    end else if (opc == 6'h08 || opc == 6'h0a || opc == 6'h23) begin
      d.op = (opc == 6'h0a) ? 4'b0111 : 4'b0010;
      d.imm = sx; d.rs1 = w[25:21]; d.rdst = w[20:16]; d.wr = 1'b1; d.ld = (opc == 6'h23);
    end else if (opc == 6'h2b) begin
      d.op = 4'b0010; d.imm = sx; d.rs1 = w[25:21]; d.rs2 = w[20:16]; d.wd = 1'b1;
    end else if (opc == 6'h04) begin
      d.op = 4'b0110; d.ssel = 1'b1; d.imm = sx; d.rs1 = w[25:21]; d.rs2 = w[20:16]; d.jt = 3'd1;
    end else if (opc == 6'h02 || opc == 6'h03) begin
      d.jt = (opc == 6'h02) ? 3'd2 : 3'd3;
      d.ja = {6'b0, w[25:0]};
      if (opc == 6'h03) begin d.rdst = 5'd31; d.wr = 1'b1; end
    end else begin
      d.ill = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [31:0] gen();
    logic [5:0] fns [6];
    logic [5:0] bad [3];
    logic [4:0] rs, rt, rd;
    logic [15:0] im;
    logic [31:0] w;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a};
    bad = '{6'h3f, 6'h01, 6'h3e};
    rs = 5'($urandom_range(0, 5));
    rt = 5'($urandom_range(0, 5));
    rd = 5'($urandom_range(0, 5));
    im = 16'($urandom);
    case ($urandom_range(0, 10))
      0:  w = {6'h00, rs, rt, rd, 5'h0, fns[$urandom_range(0, 5)]};
      1:  w = {6'h00, rs, 15'h0, 6'h08};
      2:  w = {6'h08, rs, rt, im};
      3:  w = {6'h0a, rs, rt, im};
      4:  w = {6'h23, rs, rt, im};
      5:  w = {6'h2b, rs, rt, im};
      6:  w = {6'h04, rs, rt, im};
      7:  w = {6'h02, 26'($urandom)};
      8:  w = {6'h03, 26'($urandom)};
      9:  w = {bad[$urandom_range(0, 2)], 26'($urandom)};
      default: w = {6'h00, rs, rt, rd, 5'h0, 6'h3f};
    endcase
    return w;
  endfunction

  // One clock: drive at +1, predict at +3, push accepted decode at +7 (after monitor at +5).
  task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                      input logic fl, input logic rn, output logic acc);
    dec_t m;
    logic hz;
    @(posedge clk);
    #1;
    in_valid = iv; instr = ins; out_ready = ordy; flush = fl; rst_n = rn;
    #2;
    m  = model(ins);
    hz = 1'b0;
    if (sb.size() != 0)
      hz = iv && sb[0].ld && (sb[0].rdst != 5'd0) &&
           ((sb[0].rdst == m.rs1) || (sb[0].rdst == m.rs2));
    exp_ready = rn && !fl && ((sb.size() == 0) || ordy) && !hz;
    acc = iv && exp_ready;
    #4;
    if (acc) sb.push_back(m);
`ifdef DECODE_PERF_EN
    if (!rn) begin
      exp_bub = 0; exp_ill = 0;
    end else begin
      if (!fl && hz && ordy) exp_bub++;
      if (acc && m.ill) exp_ill++;
    end
`endif
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, acc);
  endtask

  task automatic send(input logic [31:0] ins, input int ready_pct);
    logic acc;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, ins, ($urandom_range(0, 99) < ready_pct), 1'b0, 1'b1, acc);
      if (acc) return;
    end
    checks++; errors++;
    $display("FAIL accept_timeout: instr=%h not accepted, required acceptance within 20 cycles", ins);
  endtask

  always @(negedge clk) begin
    dec_t got, exp;
    if (started) begin
      got = {op, ssel, imm, rs1_id, rs2_id, rdst_id, jump_type, jump_addr,
             we_dmem, we_regfile, is_load, illegal};
      exp = (sb.size() != 0) ? sb[0] : idle_dec();
      checks++;
      if (out_valid !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL out_valid: got=%b exp=%b t=%0t", out_valid, (sb.size() != 0), $time);
      end
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL in_ready: got=%b exp=%b t=%0t", in_ready, exp_ready, $time);
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fields: got=%h exp=%h t=%0t", got, exp, $time);
      end
`ifdef DECODE_PERF_EN
      checks++;
      if (bubble_cnt !== 16'(exp_bub) || illegal_cnt !== 16'(exp_ill)) begin
        errors++;
        $display("FAIL perf_cnt: got bub=%0d ill=%0d exp bub=%0d ill=%0d",
                 bubble_cnt, illegal_cnt, exp_bub, exp_ill);
      end
`endif
      if (!rst_n || flush) sb.delete();
      else if (sb.size() != 0 && out_ready) void'(sb.pop_front());
    end
  end

  initial begin
    logic acc;
    logic [31:0] cur;
    logic iv, ordy, fl, rn;
    started = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00221820, 1'b1, 1'b0, 1'b0, acc);
    idle(1);
    send(32'h00221820, 100); idle(1);                       // add $3,$1,$2
    send(32'h8C250004, 100); send(32'h00A23020, 100);        // lw $5 ; add $6,$5,$2
    send(32'h8C200000, 100); send(32'h00023020, 100);        // lw $0 ; add $6,$0,$2
    send(32'h8C250000, 100); send(32'hAC250000, 100);        // lw $5 ; sw $5,0($1)
    send(32'h8C250000, 100); send(32'h20250001, 100);        // lw $5 ; addi $5,$1,1
    send(32'h10220008, 100);                                 // beq held under backpressure
    for (int i = 0; i < 3; i++) step(1'b1, 32'h00221820, 1'b0, 1'b0, 1'b1, acc);
    send(32'h00221820, 100);
    send(32'h8C250000, 100);
    step(1'b1, 32'h20250001, 1'b0, 1'b1, 1'b1, acc);         // flush with valid held
    idle(1);
    send(32'hFC000000, 100); idle(1);                        // illegal opcode
    send(32'h0C000123, 100);                                 // jal
    step(1'b1, 32'hAC250000, 1'b0, 1'b0, 1'b0, acc);         // reset mid-handshake
    idle(2);
    cur = gen();
    for (int i = 0; i < 800; i++) begin
      iv   = ($urandom_range(0, 99) < 85);
      ordy = ($urandom_range(0, 99) < 70);
      fl   = ($urandom_range(0, 99) < 3);
      rn   = !($urandom_range(0, 199) == 0);
      step(iv, cur, ordy, fl, rn, acc);
      if (acc || (iv && (fl || !rn))) cur = gen();
    end
    idle(4);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
